uart_frame_tx: RTL

- Transmit counterpart of the UART receive path.
- Accepts one command plus a streamed payload and wraps them in the team's packet format: 0xFE header, length, command, payload bytes, 0xEF trailer.
- Serializes every byte as 8N1, LSB first, on serial_tx. Stop time is configurable to match the receiver's framing.
- Sits between the matrix/vector result logic and the board TX pin.

---
 rtl/UART_pkg.sv | 14 +
 rtl/uart_tx_byte.sv | 109 ++++++++++
 rtl/uart_frame_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/UART_pkg.sv
// Shared types and constants for the framed UART transmit path.
// Frame layout: HDR, LEN (bytes after LEN), CMD, payload, TRL.
package UART_pkg;

    typedef logic signed [7:0] int8_t;

    localparam logic [7:0] FRAME_HDR = 8'hFE;
    localparam logic [7:0] FRAME_TRL = 8'hEF;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {IDLE, HDR, LEN, CMD, PAYLOAD, TRL, FIN} frame_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, with STOP_BITS bit times of high line after data.
// Latency: start bit on the line one cycle after load; byte_done in the last stop cycle.
// Backpressure: load is taken only when idle or in the byte_done cycle (gapless chaining).
module uart_tx_byte
    import UART_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       serial_tx,
    output logic       byte_busy,
    output logic       byte_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    ser_state_t    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        data_d    = data_q;
        byte_done = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_START;
                    data_d  = data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_last) state_d = S_DATA;
            end
            S_DATA: begin
                // bit counter wraps 7 -> 0, ready to count stop bits
                if (baud_last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        byte_done = 1'b1;
                        bit_d     = '0;
                        if (load) begin
                            state_d = S_START;
                            data_d  = data;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // line level derived from the next state so serial_tx is a clean flop output
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = data_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign serial_tx = tx_q;
    assign byte_busy = (state_q != S_IDLE);

endmodule

// File: rtl/uart_frame_tx.sv
// Wraps cmd + streamed payload as FE, N+2, cmd, payload, EF and sends it 8N1.
// Latency: header start bit one cycle after busy rises; bytes follow back-to-back.
// Backpressure: pl_ready only when the serializer can take a byte; stalls on pl_valid=0.
module uart_frame_tx
    import UART_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 2,
    parameter int MAX_PAYLOAD  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] payload_len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    output logic       serial_tx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    frame_state_t state_q, state_d;
    int8_t        cmd_q;
    logic [7:0]   len_q;
    logic [7:0]   rem_q, rem_d;
    logic         trl_loaded_q, trl_loaded_d;
    logic         err_q;
    logic         load;
    logic [7:0]   tx_byte;
    logic         byte_busy, byte_done, ser_free;
    logic         accept, reject;

    assign ser_free = !byte_busy || byte_done;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        trl_loaded_d = trl_loaded_q;
        load         = 1'b0;
        tx_byte      = 8'h00;
        pl_ready     = 1'b0;
        accept       = 1'b0;
        reject       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (payload_len > MAX_LEN) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (ser_free) begin
                    load    = 1'b1;
                    tx_byte = FRAME_HDR;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (ser_free) begin
                    load    = 1'b1;
                    tx_byte = len_q + 8'd2;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (ser_free) begin
                    load         = 1'b1;
                    tx_byte      = cmd_q;
                    rem_d        = len_q;
                    trl_loaded_d = 1'b0;
                    state_d      = (len_q == 8'd0) ? TRL : PAYLOAD;
                end
            end
            PAYLOAD: begin
                pl_ready = ser_free && (rem_q != 8'd0);
                if (pl_valid && pl_ready) begin
                    load    = 1'b1;
                    tx_byte = pl_data;
                    rem_d   = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = TRL;
                end
            end
            TRL: begin
                // the trailer's own byte_done, not the previous byte's, ends the frame
                if (!trl_loaded_q) begin
                    if (ser_free) begin
                        load         = 1'b1;
                        tx_byte      = FRAME_TRL;
                        trl_loaded_d = 1'b1;
                    end
                end else if (byte_done) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            trl_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            trl_loaded_q <= trl_loaded_d;
            err_q        <= reject;
            if (accept) begin
                cmd_q <= cmd;
                len_q <= payload_len;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);
    assign err  = err_q;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_tx_byte (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data      (tx_byte),
        .serial_tx (serial_tx),
        .byte_busy (byte_busy),
        .byte_done (byte_done)
    );

endmodule
